// File: rtl/text_console.sv
// text_console: decodes CPU register writes into cell writes for a 32x28 text display
module text_console #(
    parameter int          COLS  = 32,
    parameter int          ROWS  = 28,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] reg_di,
    input  logic        reg_we,
    output logic        reg_ready,
    output logic        busy,
    output logic [4:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic [7:0]  x_wr,
    output logic [7:0]  y_wr,
    output logic [7:0]  char_wr,
    output logic        we
);
    typedef enum logic [1:0] {S_IDLE, S_DONE, S_CLR_ROW, S_CLR_ALL} state_t;

    localparam logic [4:0] LAST_X = 5'(COLS - 1);
    localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

    state_t      r_state, w_state;
    logic [4:0]  r_cx, r_cy, r_fx, r_fy, r_x, r_y;
    logic [4:0]  w_cx, w_cy, w_fx, w_fy, w_x, w_y;
    logic [6:0]  r_ch, w_ch;
    logic        r_we, r_ready, w_we, w_ready;

    // x/y fields are taken 8 bits wide so out-of-range coordinates (e.g. 32) are rejected rather than aliased
    logic [7:0]  w_cmd, w_x8, w_y8;
    logic [6:0]  w_c;
    logic        w_xy_ok;
    logic [4:0]  w_cy_nx;
    logic        w_unused_bit;

    assign w_cmd        = reg_di[31:24];
    assign w_x8         = reg_di[23:16];
    assign w_y8         = reg_di[15:8];
    assign w_c          = reg_di[6:0];
    assign w_unused_bit = reg_di[7];
    assign w_xy_ok      = ({24'd0, w_x8} < COLS) && ({24'd0, w_y8} < ROWS);
    assign w_cy_nx      = (r_cy == LAST_Y) ? 5'd0 : r_cy + 5'd1;

    assign reg_ready = r_ready;
    assign busy      = (r_state != S_IDLE);
    assign cur_x     = r_cx;
    assign cur_y     = r_cy;
    assign x_wr      = {3'd0, r_x};
    assign y_wr      = {3'd0, r_y};
    assign char_wr   = {1'b0, r_ch};
    assign we        = r_we;

    // State and registered outputs; reset abandons any fill in progress
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_ch    <= '0;
            r_we    <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cx    <= w_cx;
            r_cy    <= w_cy;
            r_fx    <= w_fx;
            r_fy    <= w_fy;
            r_x     <= w_x;
            r_y     <= w_y;
            r_ch    <= w_ch;
            r_we    <= w_we;
            r_ready <= w_ready;
        end
    end

    // Command decode and fill sequencing; the first write of a command is issued the cycle after it is sampled
    always_comb begin
        w_state = r_state;
        w_cx    = r_cx;
        w_cy    = r_cy;
        w_fx    = r_fx;
        w_fy    = r_fy;
        w_x     = r_x;
        w_y     = r_y;
        w_ch    = r_ch;
        w_we    = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reg_we) begin
                    w_ready = 1'b1;
                    w_state = S_DONE;
                    case (w_cmd)
                        8'd0: begin
                            w_we = w_xy_ok;
                            w_x  = w_x8[4:0];
                            w_y  = w_y8[4:0];
                            w_ch = w_c;
                        end
                        8'd1: begin
                            if (w_c == 7'h0A) begin
                                w_cx    = 5'd0;
                                w_cy    = w_cy_nx;
                                w_we    = 1'b1;
                                w_x     = 5'd0;
                                w_y     = w_cy_nx;
                                w_ch    = BLANK[6:0];
                                w_fx    = 5'd1;
                                w_ready = 1'b0;
                                w_state = S_CLR_ROW;
                            end else if (w_c == 7'h0D) begin
                                w_cx = 5'd0;
                            end else if (w_c == 7'h08) begin
                                if (r_cx != 5'd0) begin
                                    w_cx = r_cx - 5'd1;
                                    w_we = 1'b1;
                                    w_x  = r_cx - 5'd1;
                                    w_y  = r_cy;
                                    w_ch = BLANK[6:0];
                                end
                            end else begin
                                w_we = 1'b1;
                                w_x  = r_cx;
                                w_y  = r_cy;
                                w_ch = w_c;
                                if (r_cx == LAST_X) begin
                                    w_cx    = 5'd0;
                                    w_cy    = w_cy_nx;
                                    w_fx    = 5'd0;
                                    w_ready = 1'b0;
                                    w_state = S_CLR_ROW;
                                end else begin
                                    w_cx = r_cx + 5'd1;
                                end
                            end
                        end
                        8'd2: begin
                            w_cx = w_xy_ok ? w_x8[4:0] : r_cx;
                            w_cy = w_xy_ok ? w_y8[4:0] : r_cy;
                        end
                        8'd3: begin
                            w_cx    = 5'd0;
                            w_cy    = 5'd0;
                            w_we    = 1'b1;
                            w_x     = 5'd0;
                            w_y     = 5'd0;
                            w_ch    = BLANK[6:0];
                            w_fx    = 5'd1;
                            w_fy    = 5'd0;
                            w_ready = 1'b0;
                            w_state = S_CLR_ALL;
                        end
                        default: ;
                    endcase
                end
            end
            S_CLR_ROW: begin
                w_we    = 1'b1;
                w_x     = r_fx;
                w_y     = r_cy;
                w_ch    = BLANK[6:0];
                w_fx    = r_fx + 5'd1;
                w_ready = (r_fx == LAST_X);
                w_state = (r_fx == LAST_X) ? S_DONE : S_CLR_ROW;
            end
            S_CLR_ALL: begin
                w_we    = 1'b1;
                w_x     = r_fx;
                w_y     = r_fy;
                w_ch    = BLANK[6:0];
                w_fx    = (r_fx == LAST_X) ? 5'd0 : r_fx + 5'd1;
                w_fy    = (r_fx == LAST_X) ? r_fy + 5'd1 : r_fy;
                w_ready = (r_fx == LAST_X) && (r_fy == LAST_Y);
                w_state = w_ready ? S_DONE : S_CLR_ALL;
            end
            default: w_state = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_text_console.sv
// tb_text_console: directed scoreboard bench for the text console engine
module tb_text_console;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] reg_di = '0;
    logic        reg_we = 1'b0;
    logic        reg_ready, busy, we;
    logic [4:0]  cur_x, cur_y;
    logic [7:0]  x_wr, y_wr, char_wr;

    int tests = 0;
    int fails = 0;
    int lat;
    logic [23:0] sb[$];

    text_console dut (
        .clk(clk), .resetn(resetn), .reg_di(reg_di), .reg_we(reg_we),
        .reg_ready(reg_ready), .busy(busy), .cur_x(cur_x), .cur_y(cur_y),
        .x_wr(x_wr), .y_wr(y_wr), .char_wr(char_wr), .we(we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // every display write must match the next expected cell in order
    always @(negedge clk) begin
        if (we === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_we: observed %0h expected none", {x_wr, y_wr, char_wr});
            end
            if (sb.size() != 0) check("we_cell", {8'd0, x_wr, y_wr, char_wr}, {8'd0, sb.pop_front()});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk(input logic [7:0] c, input logic [7:0] x, input logic [7:0] y, input logic [6:0] ch);
        return {c, x, y, 1'b0, ch};
    endfunction

    task automatic push(input int x, input int y, input int ch);
        sb.push_back({8'(x), 8'(y), 8'(ch)});
    endtask

    task automatic do_cmd(input logic [31:0] w, input int max_cyc, output int l);
        @(negedge clk);
        reg_di = w;
        reg_we = 1'b1;
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (reg_ready !== 1'b1 && l < max_cyc);
        reg_we = 1'b0;
    endtask

    task automatic cmd_chk(input string tag, input logic [31:0] w, input int max_cyc, input int exp_lat, input int ex, input int ey);
        do_cmd(w, max_cyc, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_cur"}, {cur_x, cur_y}, {5'(ex), 5'(ey)});
        #1;
        check({tag, "_sb"}, sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out", {we, reg_ready, busy, cur_x, cur_y, x_wr, y_wr, char_wr}, 0);
        resetn = 1'b1;

        push(3, 5, 8'h41);
        do_cmd(mk(0, 3, 5, 7'h41), 10, lat);
        check("wr_lat", lat, 1);
        check("wr_busy_done", busy, 1);
        check("wr_cur", {cur_x, cur_y}, 0);
        @(negedge clk);
        check("wr_idle", busy, 0);

        cmd_chk("wr_x32", mk(0, 32, 0, 7'h41), 10, 1, 0, 0);
        cmd_chk("wr_y28", mk(0, 0, 28, 7'h42), 10, 1, 0, 0);
        push(31, 27, 8'h43);
        cmd_chk("wr_corner", mk(0, 31, 27, 7'h43), 10, 1, 0, 0);

        cmd_chk("cur_set", mk(2, 31, 27, 0), 10, 1, 31, 27);
        cmd_chk("cur_bad", mk(2, 40, 3, 0), 10, 1, 31, 27);

        push(31, 27, 8'h5A);
        for (int i = 0; i < 32; i++) push(i, 0, 8'h20);
        cmd_chk("putc_wrap", mk(1, 0, 0, 7'h5A), 100, 33, 0, 0);

        cmd_chk("cur_04", mk(2, 0, 4, 0), 10, 1, 0, 4);
        cmd_chk("bs_edge", mk(1, 0, 0, 7'h08), 10, 1, 0, 4);
        cmd_chk("cur_54", mk(2, 5, 4, 0), 10, 1, 5, 4);
        push(4, 4, 8'h20);
        cmd_chk("bs", mk(1, 0, 0, 7'h08), 10, 1, 4, 4);
        push(4, 4, 8'h62);
        cmd_chk("putc_b", mk(1, 0, 0, 7'h62), 10, 1, 5, 4);
        cmd_chk("cr", mk(1, 0, 0, 7'h0D), 10, 1, 0, 4);
        for (int i = 0; i < 32; i++) push(i, 5, 8'h20);
        cmd_chk("lf", mk(1, 0, 0, 7'h0A), 100, 32, 0, 5);
        cmd_chk("cur_27", mk(2, 3, 27, 0), 10, 1, 3, 27);
        for (int i = 0; i < 32; i++) push(i, 0, 8'h20);
        cmd_chk("lf_wrap", mk(1, 0, 0, 7'h0A), 100, 32, 0, 0);
        cmd_chk("cur_99", mk(2, 9, 9, 0), 10, 1, 9, 9);
        cmd_chk("nop", mk(7, 1, 1, 7'h41), 10, 1, 9, 9);

        for (int i = 0; i < 896; i++) push(i % 32, i / 32, 8'h20);
        cmd_chk("cls", mk(3, 0, 0, 0), 2000, 896, 0, 0);

        cmd_chk("cur_77", mk(2, 7, 7, 0), 10, 1, 7, 7);
        for (int i = 0; i < 896; i++) push(i % 32, i / 32, 8'h20);
        @(negedge clk);
        reg_di = mk(3, 0, 0, 0);
        reg_we = 1'b1;
        repeat (100) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_out", {we, reg_ready, busy, cur_x, cur_y}, 0);
        check("rst_mid_cnt", sb.size(), 796);
        sb.delete();
        reg_we = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold", {we, reg_ready, busy}, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {we, reg_ready, busy}, 0);
        push(7, 7, 8'h71);
        cmd_chk("post_rst_wr", mk(0, 7, 7, 7'h71), 10, 1, 0, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
